clkswitch_m: RTL and testbench



---
 rtl/clkswitch_pkg.sv | 39 +++
 rtl/clkswitch_if.sv | 25 ++
 rtl/clkswitch_sync2.sv | 43 ++++
 rtl/clkswitch_m.sv | 134 +++++++++++++
 tb/tb_clkswitch_m.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clkswitch_pkg.sv
// Shared definitions for the level1b CPU clock switch: state encodings,
// divider codes, config register layout and the phase-length lookup.
`timescale 1ns/1ps
package clkswitch_pkg;

   typedef enum logic [1:0] {
      LS_RUN       = 2'd0,
      HS_RUN       = 2'd1,
      SW_WAIT_FALL = 2'd2,
      SW_WAIT_RISE = 2'd3
   } sw_state_e;

   localparam logic [1:0] DIV_1_A = 2'b00;
   localparam logic [1:0] DIV_1_B = 2'b01;
   localparam logic [1:0] DIV_2   = 2'b10;
   localparam logic [1:0] DIV_4   = 2'b11;

   // Config register layout, shared with the register block.
   typedef struct packed {
      logic [3:0] rsvd_hi;
      logic       hs_en;
      logic       rsvd_2;
      logic [1:0] div;
   } cfg_reg_t;

   // Last phase-counter value for a divider code (phase length minus one).
   function automatic logic [1:0] phase_last(input logic [1:0] div);
      logic [1:0] last;
      case (div)
         DIV_1_A: last = 2'd0;
         DIV_1_B: last = 2'd0;
         DIV_2:   last = 2'd1;
         DIV_4:   last = 2'd3;
         default: last = 2'd0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/clkswitch_if.sv
// Decode, config and clock-status signals between the clock switch and the
// CPU / host-bus logic.
`timescale 1ns/1ps
interface clkswitch_if;
   import clkswitch_pkg::*;

   logic       cfg_hs_en;
   logic [1:0] cfg_div;
   logic       himem;
   logic       vpa;
   logic       vda;
   logic       cpu_ck_phi2;
   logic       hs_active;
   logic       switching;

   modport master (
      output cfg_hs_en, cfg_div, himem, vpa, vda,
      input  cpu_ck_phi2, hs_active, switching
   );

   modport slave (
      input  cfg_hs_en, cfg_div, himem, vpa, vda,
      output cpu_ck_phi2, hs_active, switching
   );
endinterface

// File: rtl/clkswitch_sync2.sv
// N-flop synchroniser for a host-clock input with single-cycle rise/fall
// detects on the synchronised value.
`timescale 1ns/1ps
module sync2_m
   import clkswitch_pkg::*;
#(
   parameter int N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [N-1:0] stage_q;
   logic [N-1:0] stage_d;
   logic         prev_q;
   logic         prev_d;

   // Next values of the synchroniser chain and the edge-detect history flop.
   always_comb begin
      stage_d = {stage_q[N-2:0], d};
      prev_d  = stage_q[N-1];
   end

   // Synchroniser and history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= {N{1'b0}};
         prev_q  <= 1'b0;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
      end
   end

   assign q    = stage_q[N-1];
   assign rise = stage_q[N-1] & ~prev_q;
   assign fall = ~stage_q[N-1] & prev_q;

endmodule

// File: rtl/clkswitch_m.sv
// CPU clock generator: divided bbc_ck8 in HS mode, locked to the host phi0
// in LS mode, switching on decode sampled at the end of CPU phi1.
`timescale 1ns/1ps
module clkswitch_m
   import clkswitch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        bbc_ck8,
   input  logic        reset,
   input  logic        bbc_ck2_phi0,
   clkswitch_if.slave  bus
);

   sw_state_e  state_q, state_d;
   logic       ck_q, ck_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] last_q, last_d;
   logic       hs_active_q, hs_active_d;
   logic       switching_q, switching_d;

   logic phi0_s;
   logic p0_rise;
   logic p0_fall;
   logic go_hs_s;
   logic go_ls_s;
   logic expire_s;

   sync2_m #(.N(SYNC_STAGES)) u_sync (
      .clk   (bbc_ck8),
      .reset (reset),
      .d     (bbc_ck2_phi0),
      .q     (phi0_s),
      .rise  (p0_rise),
      .fall  (p0_fall)
   );

   // Switch decode; an internal cycle (vpa=vda=0) never requests a switch.
   always_comb begin
      go_hs_s  = bus.cfg_hs_en & bus.himem & bus.vpa & bus.vda;
      go_ls_s  = (bus.vpa | bus.vda) & (~bus.cfg_hs_en | ~bus.himem);
      expire_s = (cnt_q == last_q);
   end

   // Next-state and clock-level logic.
   always_comb begin
      state_d = state_q;
      ck_d    = ck_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         LS_RUN: begin
            cnt_d = 2'd0;
            if (p0_rise) begin
               ck_d = 1'b1;
               if (go_hs_s) begin
                  state_d = HS_RUN;
                  last_d  = phase_last(bus.cfg_div);
               end else begin
                  state_d = LS_RUN;
               end
            end else begin
               ck_d = phi0_s;
            end
         end
         HS_RUN: begin
            if (expire_s) begin
               // The divider is picked up only here so a phase is never cut short.
               cnt_d  = 2'd0;
               last_d = phase_last(bus.cfg_div);
               if (ck_q) begin
                  ck_d = 1'b0;
               end else if (go_ls_s) begin
                  ck_d    = 1'b0;
                  state_d = SW_WAIT_FALL;
               end else begin
                  ck_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         SW_WAIT_FALL: begin
            ck_d = 1'b0;
            if (p0_fall) begin
               state_d = SW_WAIT_RISE;
            end else begin
               state_d = SW_WAIT_FALL;
            end
         end
         SW_WAIT_RISE: begin
            // Leave on a host rise so the first LS phi2 is a full host phi2.
            if (p0_rise) begin
               ck_d    = 1'b1;
               state_d = LS_RUN;
            end else begin
               ck_d    = 1'b0;
               state_d = SW_WAIT_RISE;
            end
         end
         default: begin
            state_d = LS_RUN;
            ck_d    = 1'b0;
            cnt_d   = 2'd0;
         end
      endcase
      hs_active_d = (state_d == HS_RUN);
      switching_d = (state_d == SW_WAIT_FALL) | (state_d == SW_WAIT_RISE);
   end

   // State, clock and status registers.
   always_ff @(posedge bbc_ck8) begin
      if (reset) begin
         state_q     <= LS_RUN;
         ck_q        <= 1'b0;
         cnt_q       <= 2'd0;
         last_q      <= 2'd0;
         hs_active_q <= 1'b0;
         switching_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ck_q        <= ck_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         hs_active_q <= hs_active_d;
         switching_q <= switching_d;
      end
   end

   assign bus.cpu_ck_phi2 = ck_q;
   assign bus.hs_active   = hs_active_q;
   assign bus.switching   = switching_q;

endmodule

// File: tb/tb_clkswitch_m.sv
// Bench for clkswitch_m: directed steps plus random decode, each cycle
// compared against a cycle-level behavioural model of the switch rules.
`timescale 1ns/1ps
module tb_clkswitch_m;

   localparam int S    = 2;
   localparam int M_LS = 100;
   localparam int M_HS = 101;
   localparam int M_WF = 102;
   localparam int M_WR = 103;

   typedef struct packed {
      int         mode;
      logic       ck;
      int         left;
      logic [7:0] hist;
   } model_t;

   logic bbc_ck8      = 1'b0;
   logic reset        = 1'b1;
   logic bbc_ck2_phi0 = 1'b0;

   clkswitch_if bus ();

   clkswitch_m #(.SYNC_STAGES(S)) dut (
      .bbc_ck8      (bbc_ck8),
      .reset        (reset),
      .bbc_ck2_phi0 (bbc_ck2_phi0),
      .bus          (bus)
   );

   initial forever #59 bbc_ck8 = ~bbc_ck8;
   initial begin
      #337.5;
      forever #1000 bbc_ck2_phi0 = ~bbc_ck2_phi0;
   end

   model_t m;
   int     n_chk  = 0;
   int     n_pass = 0;
   int     cyc    = 0;
   int     rises  = 0;
   int     rise_last = 0;
   int     rise_prev = 0;
   logic   last_ck = 1'b0;
   logic   hs_seen = 1'b0;
   int     per;

   function automatic int plen(input logic [1:0] div);
      return div[1] ? (div[0] ? 4 : 2) : 1;
   endfunction

   function automatic model_t model_reset();
      model_t r;
      r.mode = M_LS;
      r.ck   = 1'b0;
      r.left = 1;
      r.hist = 8'h00;
      return r;
   endfunction

   // hist[k] is the host clock as seen k+1 edges ago; phi0_s lags it by S edges.
   function automatic model_t model_next(input model_t c, input logic p0, input logic en,
                                         input logic [1:0] div, input logic hm,
                                         input logic pa, input logic da);
      model_t n;
      logic s_now, s_prev, rise, fall, go_hs, go_ls;
      n      = c;
      s_now  = c.hist[S-1];
      s_prev = c.hist[S];
      rise   = s_now && !s_prev;
      fall   = !s_now && s_prev;
      go_hs  = en && hm && pa && da;
      go_ls  = (pa || da) && (!en || !hm);
      n.hist = {c.hist[6:0], p0};
      if (c.mode == M_LS) begin
         n.ck = s_now;
         if (rise && go_hs) begin
            n.mode = M_HS;
            n.left = plen(div);
         end
      end else if (c.mode == M_HS) begin
         n.left = c.left - 1;
         if (n.left == 0) begin
            n.left = plen(div);
            if (c.ck) n.ck = 1'b0;
            else if (go_ls) n.mode = M_WF;
            else n.ck = 1'b1;
         end
      end else if (c.mode == M_WF) begin
         n.ck = 1'b0;
         if (fall) n.mode = M_WR;
      end else begin
         n.ck = rise;
         if (rise) n.mode = M_LS;
      end
      return n;
   endfunction

   always @(posedge bbc_ck8) begin
      if (reset) m <= model_reset();
      else m <= model_next(m, bbc_ck2_phi0, bus.cfg_hs_en, bus.cfg_div,
                           bus.himem, bus.vpa, bus.vda);
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b, expected %b (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge bbc_ck8);
         #1;
         cyc++;
         chk1("ck", bus.cpu_ck_phi2, m.ck);
         chk1("hs_active", bus.hs_active, m.mode == M_HS);
         chk1("switching", bus.switching, (m.mode == M_WF) || (m.mode == M_WR));
         if (bus.hs_active === 1'b1) hs_seen = 1'b1;
         if (bus.cpu_ck_phi2 === 1'b1 && last_ck === 1'b0) begin
            rises++;
            rise_prev = rise_last;
            rise_last = cyc;
         end
         last_ck = bus.cpu_ck_phi2;
      end
   endtask

   function automatic logic cond_met(input int which);
      case (which)
         0:       return bus.hs_active === 1'b1;
         1:       return bus.switching === 1'b1;
         2:       return bus.switching === 1'b0;
         default: return m.mode == M_WR;
      endcase
   endfunction

   task automatic wait_for(input int which, input int budget, input string tag);
      int k = 0;
      while (!cond_met(which) && k < budget) begin
         step(1);
         k++;
      end
      chk1({tag, "_reached"}, cond_met(which), 1'b1);
   endtask

   // Rise-to-rise distance of cpu_ck_phi2 over the second of two fresh rises.
   task automatic measure_period(output int p);
      int start = rises;
      int k = 0;
      while (rises < start + 2 && k < 300) begin
         step(1);
         k++;
      end
      chk1("period_timeout", rises >= start + 2, 1'b1);
      p = rise_last - rise_prev;
   endtask

   initial begin
      bus.cfg_hs_en = 1'b0;
      bus.cfg_div   = 2'b00;
      bus.himem     = 1'b1;
      bus.vpa       = 1'b1;
      bus.vda       = 1'b1;
      reset         = 1'b1;
      step(4);
      chk1("rst_ck", bus.cpu_ck_phi2, 1'b0);
      chk1("rst_hs_active", bus.hs_active, 1'b0);
      chk1("rst_switching", bus.switching, 1'b0);
      reset = 1'b0;

      // HS disabled: stays LS, ck follows phi0 sampled S edges earlier.
      for (int i = 0; i < 80; i++) begin
         step(1);
         chk1("ls_lag", bus.cpu_ck_phi2, m.hist[S]);
      end
      chk1("no_hs_when_disabled", hs_seen, 1'b0);
      measure_period(per);
      chk1("ls_period_initial", (per >= 16) && (per <= 17), 1'b1);

      // Enter HS on a himem fetch; div 00 gives a 2-cycle period.
      bus.cfg_hs_en = 1'b1;
      wait_for(0, 60, "hs_entry");
      measure_period(per);
      chkn("hs_period_div00", per, 2);
      bus.vpa = 1'b0;
      step(12);
      chk1("hs_kept_data_read", bus.hs_active, 1'b1);
      bus.vpa = 1'b1;

      bus.cfg_div = 2'b10;
      measure_period(per);
      chkn("hs_period_div10", per, 4);
      bus.cfg_div = 2'b11;
      measure_period(per);
      chkn("hs_period_div11", per, 8);

      // Leave HS on a non-himem data access.
      bus.himem = 1'b0;
      bus.vpa   = 1'b0;
      bus.vda   = 1'b1;
      wait_for(1, 20, "sw_start");
      chk1("sw_ck_held", bus.cpu_ck_phi2, 1'b0);
      wait_for(2, 60, "sw_done");
      chk1("sw_exit_ck_rise", bus.cpu_ck_phi2, 1'b1);
      chk1("sw_exit_hs_active", bus.hs_active, 1'b0);
      measure_period(per);
      chk1("ls_period_after_switch", (per >= 16) && (per <= 17), 1'b1);

      // Random decode and config traffic.
      for (int i = 0; i < 1500; i++) begin
         bus.cfg_hs_en = ($urandom_range(0, 7) != 0);
         bus.himem     = ($urandom_range(0, 3) != 0);
         bus.vpa       = 1'($urandom_range(0, 1));
         bus.vda       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) bus.cfg_div = 2'($urandom_range(0, 3));
         step(1);
      end

      // Reset while waiting for the host rise.
      bus.cfg_hs_en = 1'b1;
      bus.cfg_div   = 2'b00;
      bus.himem     = 1'b1;
      bus.vpa       = 1'b1;
      bus.vda       = 1'b1;
      wait_for(0, 60, "hs_reentry");
      bus.himem = 1'b0;
      bus.vpa   = 1'b0;
      wait_for(3, 80, "wait_rise");
      chk1("in_wait_rise_switching", bus.switching, 1'b1);
      reset = 1'b1;
      step(1);
      chk1("rst_mid_sw_ck", bus.cpu_ck_phi2, 1'b0);
      chk1("rst_mid_sw_switching", bus.switching, 1'b0);
      chk1("rst_mid_sw_hs_active", bus.hs_active, 1'b0);
      reset = 1'b0;
      step(1);
      chk1("no_glitch_1", bus.cpu_ck_phi2, 1'b0);
      step(1);
      chk1("no_glitch_2", bus.cpu_ck_phi2, 1'b0);
      step(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
